target_scheduler: RTL and testbench



---
 rtl/target_scheduler.sv | 122 ++++++++++++
 tb/tb_target_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/target_scheduler.sv
// Target scheduler: seeds the LFSR target generator, screens its candidates
// against screen bounds and the snake head, and publishes one (X,Y) target.
module target_scheduler #(
  parameter int          X_MAX     = 160,
  parameter int          Y_MAX     = 120,
  parameter int          MAX_TRIES = 64,
  parameter int          DEFAULT_X = 80,
  parameter int          DEFAULT_Y = 60,
  parameter logic [15:0] SEED_SALT = 16'h0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_new,
  input  logic [7:0]  head_x,
  input  logic [6:0]  head_y,
  input  logic [7:0]  gen_x,
  input  logic [6:0]  gen_y,
  output logic        gen_trigger,
  output logic [15:0] gen_seed,
  output logic [7:0]  target_x,
  output logic [6:0]  target_y,
  output logic        target_valid,
  output logic        new_target,
  output logic        busy
);

  localparam int          TW       = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [8:0]  XM       = 9'(X_MAX);
  localparam logic [7:0]  YM       = 8'(Y_MAX);
  localparam logic [15:0] SEED_DEF = 16'hACE1;

  // LOAD covers the cycle where the generator is absorbing the seed, so the
  // first CHECK sees the freshly seeded output.
  typedef enum logic [1:0] {S_IDLE, S_SEED, S_LOAD, S_CHECK} state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_seed_cnt;
  logic [TW-1:0] r_tries;
  logic          r_gen_trigger;
  logic [15:0]   r_gen_seed;
  logic [7:0]    r_target_x;
  logic [6:0]    r_target_y;
  logic          r_target_valid;
  logic          r_new_target;
  logic          r_busy;

  logic [15:0]   w_salted;
  logic [15:0]   w_seed;
  logic          w_accept;
  logic          w_last;

  assign w_salted = r_seed_cnt ^ SEED_SALT;
  assign w_seed   = (w_salted == 16'h0000) ? SEED_DEF : w_salted;
  assign w_accept = ({1'b0, gen_x} < XM) && ({1'b0, gen_y} < YM) &&
                    !((gen_x == head_x) && (gen_y == head_y));
  assign w_last   = (r_tries == TW'(MAX_TRIES - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_new) w_state_nxt = S_SEED;
      S_SEED:  w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_CHECK;
      S_CHECK: if (w_accept || w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state        <= S_IDLE;
      r_seed_cnt     <= '0;
      r_tries        <= '0;
      r_gen_trigger  <= 1'b0;
      r_gen_seed     <= SEED_DEF;
      r_target_x     <= '0;
      r_target_y     <= '0;
      r_target_valid <= 1'b0;
      r_new_target   <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_seed_cnt    <= r_seed_cnt + 16'd1;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_gen_trigger <= (r_state == S_SEED);
      r_new_target  <= 1'b0;
      case (r_state)
        S_IDLE: if (req_new) begin
          r_gen_seed     <= w_seed;
          r_target_valid <= 1'b0;
          r_tries        <= '0;
        end
        S_CHECK: begin
          if (w_accept) begin
            r_target_x     <= gen_x;
            r_target_y     <= gen_y;
            r_target_valid <= 1'b1;
            r_new_target   <= 1'b1;
          end else if (w_last) begin
            // Default is published even if it sits on the head.
            r_target_x     <= 8'(DEFAULT_X);
            r_target_y     <= 7'(DEFAULT_Y);
            r_target_valid <= 1'b1;
            r_new_target   <= 1'b1;
          end else begin
            r_tries <= r_tries + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign gen_trigger  = r_gen_trigger;
  assign gen_seed     = r_gen_seed;
  assign target_x     = r_target_x;
  assign target_y     = r_target_y;
  assign target_valid = r_target_valid;
  assign new_target   = r_new_target;
  assign busy         = r_busy;

endmodule

// File: tb/tb_target_scheduler.sv
// Scoreboard bench for target_scheduler with an LFSR generator stub and a
// candidate-sequence reference model.
module tb_target_scheduler;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req_new = 1'b0;
  logic [7:0]  head_x = '0;
  logic [6:0]  head_y = '0;
  logic [7:0]  gen_x;
  logic [6:0]  gen_y;
  logic        gen_trigger;
  logic [15:0] gen_seed;
  logic [7:0]  target_x;
  logic [6:0]  target_y;
  logic        target_valid;
  logic        new_target;
  logic        busy;

  target_scheduler dut (
    .CLK(CLK), .RESET(RESET), .req_new(req_new),
    .head_x(head_x), .head_y(head_y), .gen_x(gen_x), .gen_y(gen_y),
    .gen_trigger(gen_trigger), .gen_seed(gen_seed),
    .target_x(target_x), .target_y(target_y), .target_valid(target_valid),
    .new_target(new_target), .busy(busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Generator stub: loads on trigger, otherwise free-runs.
  logic [15:0] lfsr = 16'h0001;
  bit          stub_const = 1'b0;
  always @(posedge CLK) lfsr <= gen_trigger ? gen_seed : lfsr_next(lfsr);
  assign gen_x = stub_const ? 8'd200 : lfsr[7:0];
  assign gen_y = lfsr[14:8];

  // Cycle count and the seed counter as defined: cycles since reset release.
  int          cyc = 0;
  logic [15:0] scnt = '0;
  always @(posedge CLK) begin
    cyc  <= cyc + 1;
    scnt <= RESET ? 16'h0 : scnt + 16'd1;
  end

  typedef struct { logic [7:0] x; logic [6:0] y; int c; } pub_t;
  typedef struct { logic [15:0] seed; int c; } trg_t;
  pub_t pq[$];
  trg_t tq[$];

  int errs = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Walk candidates: candidate i is decided i cycles after the first.
  function automatic pub_t model(input logic [15:0] seed, input logic [7:0] hx,
                                 input logic [6:0] hy, input bit cmode, input int c0);
    pub_t r;
    logic [15:0] l;
    logic [7:0] x;
    logic [6:0] y;
    l = seed;
    for (int i = 0; i < 64; i++) begin
      x = cmode ? 8'd200 : l[7:0];
      y = l[14:8];
      if (x < 8'd160 && y < 7'd120 && !(x == hx && y == hy)) begin
        r.x = x; r.y = y; r.c = c0 + i;
        return r;
      end
      l = lfsr_next(l);
    end
    r.x = 8'd80; r.y = 7'd60; r.c = c0 + 63;
    return r;
  endfunction

  // Monitor
  logic prev_trig = 1'b0;
  always @(negedge CLK) begin
    if (!RESET) begin
      if (gen_trigger) begin
        chk("trigger_width", 32'(prev_trig), 32'd0);
        if (tq.size() == 0) chk("trigger_unexpected", 32'(gen_trigger), 32'd0);
        else begin
          trg_t t;
          t = tq.pop_front();
          chk("gen_seed", 32'(gen_seed), 32'(t.seed));
          chk("trigger_cycle", cyc, t.c);
          chk("busy_in_search", 32'(busy), 32'd1);
          chk("valid_cleared", 32'(target_valid), 32'd0);
        end
      end
      if (new_target) begin
        if (pq.size() == 0) chk("new_target_unexpected", 32'(new_target), 32'd0);
        else begin
          pub_t p;
          p = pq.pop_front();
          chk("target_x", 32'(target_x), 32'(p.x));
          chk("target_y", 32'(target_y), 32'(p.y));
          chk("publish_cycle", cyc, p.c);
          chk("target_valid", 32'(target_valid), 32'd1);
          chk("busy_after_publish", 32'(busy), 32'd0);
        end
      end
    end
    prev_trig = gen_trigger;
  end

  // Call at a negedge: drives req_new for the next edge.
  task automatic do_req(input logic [7:0] hx, input logic [6:0] hy, input bit cmode);
    logic [15:0] s;
    trg_t t;
    s = scnt;
    if (s == 16'h0) s = 16'hACE1;
    head_x = hx; head_y = hy; stub_const = cmode;
    req_new = 1'b1;
    t.seed = s; t.c = cyc + 2;
    tq.push_back(t);
    pq.push_back(model(s, hx, hy, cmode, cyc + 4));
    @(negedge CLK);
    req_new = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((pq.size() != 0 || tq.size() != 0) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) begin
      chk("timeout_pending", pq.size(), 0);
      pq.delete(); tq.delete();
    end
    @(negedge CLK);
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    pq.delete(); tq.delete();
    repeat (n) @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    logic [15:0] s;
    int c0;
    // Reset values after 3 cycles of reset
    repeat (3) @(negedge CLK);
    chk("rst_trigger", 32'(gen_trigger), 32'd0);
    chk("rst_seed", 32'(gen_seed), 32'hACE1);
    chk("rst_tx", 32'(target_x), 32'd0);
    chk("rst_ty", 32'(target_y), 32'd0);
    chk("rst_valid", 32'(target_valid), 32'd0);
    chk("rst_new", 32'(new_target), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Request on the first free cycle: seed_cnt=0 maps to ACE1
    RESET = 1'b0;
    do_req(8'd0, 7'd0, 1'b0);
    wait_done();
    // Back-to-back request shows the counter advancing
    do_req(8'd3, 7'd4, 1'b0);
    wait_done();

    // Seed 0x1234, head at origin
    do_reset(1);
    while (scnt != 16'h1234) @(negedge CLK);
    do_req(8'd0, 7'd0, 1'b0);
    wait_done();
    chk("t2_x", 32'(target_x), 32'd52);
    chk("t2_y", 32'(target_y), 32'd18);
    chk("t2_valid", 32'(target_valid), 32'd1);

    // Same seed, head on the first candidate
    do_reset(1);
    while (scnt != 16'h1234) @(negedge CLK);
    do_req(8'd52, 7'd18, 1'b0);
    wait_done();
    chk("t3_not_head", 32'(target_x == 8'd52 && target_y == 7'd18), 32'd0);

    // Every candidate off-screen -> default after 64 checks, with req_new noise
    @(negedge CLK);
    do_req(8'd80, 7'd60, 1'b1);
    repeat (10) begin
      req_new = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    req_new = 1'b0;
    wait_done();
    chk("t4_x", 32'(target_x), 32'd80);
    chk("t4_y", 32'(target_y), 32'd60);
    chk("t4_busy", 32'(busy), 32'd0);

    // Reset during the second CHECK cycle
    c0 = cyc;
    do_req(8'd0, 7'd0, 1'b1);
    repeat (3) @(negedge CLK);
    do_reset(1);
    chk("t6_reset_cycle", cyc, c0 + 5);
    chk("t6_valid", 32'(target_valid), 32'd0);
    chk("t6_new", 32'(new_target), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_trigger", 32'(gen_trigger), 32'd0);
    @(negedge CLK);
    do_req(8'd1, 7'd1, 1'b0);
    wait_done();

    // Randomized requests, sometimes with the head on the first candidate
    repeat (30) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      s = scnt;
      if (s == 16'h0) s = 16'hACE1;
      if ($urandom_range(0, 3) == 0) do_req(s[7:0], s[14:8], 1'b0);
      else do_req(8'($urandom), 7'($urandom), 1'b0);
      wait_done();
    end

    chk("final_pending", pq.size() + tq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
